// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Operands are registered toward the ALU; the result is registered and returned to the granted client.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_rdata1,
  input  logic [WIDTH-1:0] req0_rdata2,
  input  logic [WIDTH-1:0] req0_pc,
  input  logic [WIDTH-1:0] req0_imm,
  input  logic             req0_asel,
  input  logic             req0_bsel,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_rdata1,
  input  logic [WIDTH-1:0] req1_rdata2,
  input  logic [WIDTH-1:0] req1_pc,
  input  logic [WIDTH-1:0] req1_imm,
  input  logic             req1_asel,
  input  logic             req1_bsel,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [WIDTH-1:0] alu_rdata1,
  output logic [WIDTH-1:0] alu_rdata2,
  output logic [WIDTH-1:0] alu_pc,
  output logic [WIDTH-1:0] alu_imm,
  output logic             alu_asel,
  output logic             alu_bsel,
  output logic [OPW-1:0]   alu_operation,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic [WIDTH-1:0] rdata2_q, rdata2_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic             asel_q, asel_d;
  logic             bsel_q, bsel_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic grant_c;
  logic accept_c;
  logic rsp_ready_c;

  // Contention goes to rr_ptr; a lone requester always wins.
  always_comb begin
    grant_c = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_c = rr_ptr_q;
    end
  end

  // Ready is gated by reset so nothing handshakes while rst is held.
  assign req0_ready  = ~rst && (state_q == IDLE) && req0_valid && ~grant_c;
  assign req1_ready  = ~rst && (state_q == IDLE) && req1_valid &&  grant_c;
  assign accept_c    = req0_ready || req1_ready;
  assign rsp_ready_c = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    asel_d   = asel_q;
    bsel_d   = bsel_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          rdata1_d = grant_c ? req1_rdata1 : req0_rdata1;
          rdata2_d = grant_c ? req1_rdata2 : req0_rdata2;
          pc_d     = grant_c ? req1_pc     : req0_pc;
          imm_d    = grant_c ? req1_imm    : req0_imm;
          asel_d   = grant_c ? req1_asel   : req0_asel;
          bsel_d   = grant_c ? req1_bsel   : req0_bsel;
          op_d     = grant_c ? req1_op     : req0_op;
          owner_d  = grant_c;
          rr_ptr_d = ~grant_c;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      asel_q   <= 1'b0;
      bsel_q   <= 1'b0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      asel_q   <= asel_d;
      bsel_q   <= bsel_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign rsp0_valid    = (state_q == RESP) && ~owner_q;
  assign rsp1_valid    = (state_q == RESP) &&  owner_q;
  assign rsp0_result   = result_q;
  assign rsp1_result   = result_q;
  assign alu_rdata1    = rdata1_q;
  assign alu_rdata2    = rdata2_q;
  assign alu_pc        = pc_q;
  assign alu_imm       = imm_q;
  assign alu_asel      = asel_q;
  assign alu_bsel      = bsel_q;
  assign alu_operation = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle, plus literal result pins.
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       rq_valid;
  logic [1:0][31:0] rq_rd1, rq_rd2, rq_pc, rq_imm;
  logic [1:0]       rq_asel, rq_bsel;
  logic [1:0][3:0]  rq_op;
  logic [1:0]       rs_ready;
  logic [1:0]       dut_rdy;
  logic [1:0]       dut_rsp_v;
  logic [1:0][31:0] dut_res;
  logic [31:0]      alu_rdata1, alu_rdata2, alu_pc, alu_imm, alu_result;
  logic             alu_asel, alu_bsel;
  logic [3:0]       alu_operation;

  int n_vec;
  int n_fail;

  // Model of the arbiter at transaction level.
  logic        m_pend;
  int          m_age;
  int          m_owner;
  int          m_last;
  int          m_acc;
  logic [31:0] m_a1, m_a2, m_pc, m_imm, m_res;
  logic        m_as, m_bs;
  logic [3:0]  m_op;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:    ref_alu = a + b;
      4'd1:    ref_alu = a - b;
      4'd2:    ref_alu = a & b;
      4'd3:    ref_alu = a | b;
      4'd4:    ref_alu = a << b[4:0];
      4'd5:    ref_alu = a >> b[4:0];
      4'd6:    ref_alu = 32'($signed(a) >>> b[4:0]);
      4'd7:    ref_alu = {31'd0, (a < b)};
      4'd8:    ref_alu = {31'd0, ($signed(a) < $signed(b))};
      default: ref_alu = 32'd0;
    endcase
  endfunction

  // Stand-in for the external ALU.
  assign alu_result = ref_alu(alu_asel ? alu_pc : alu_rdata1, alu_bsel ? alu_imm : alu_rdata2,
                              alu_operation);

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(rq_valid[0]), .req0_ready(dut_rdy[0]),
    .req0_rdata1(rq_rd1[0]), .req0_rdata2(rq_rd2[0]), .req0_pc(rq_pc[0]), .req0_imm(rq_imm[0]),
    .req0_asel(rq_asel[0]), .req0_bsel(rq_bsel[0]), .req0_op(rq_op[0]),
    .req1_valid(rq_valid[1]), .req1_ready(dut_rdy[1]),
    .req1_rdata1(rq_rd1[1]), .req1_rdata2(rq_rd2[1]), .req1_pc(rq_pc[1]), .req1_imm(rq_imm[1]),
    .req1_asel(rq_asel[1]), .req1_bsel(rq_bsel[1]), .req1_op(rq_op[1]),
    .rsp0_valid(dut_rsp_v[0]), .rsp0_ready(rs_ready[0]), .rsp0_result(dut_res[0]),
    .rsp1_valid(dut_rsp_v[1]), .rsp1_ready(rs_ready[1]), .rsp1_result(dut_res[1]),
    .alu_rdata1(alu_rdata1), .alu_rdata2(alu_rdata2), .alu_pc(alu_pc), .alu_imm(alu_imm),
    .alu_asel(alu_asel), .alu_bsel(alu_bsel), .alu_operation(alu_operation),
    .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_age = 0; m_owner = 0; m_last = 1; m_acc = -1;
    m_a1 = '0; m_a2 = '0; m_pc = '0; m_imm = '0; m_res = '0;
    m_as = 1'b0; m_bs = 1'b0; m_op = '0;
  endtask

  // Idle, valid, and either uncontested or not the most recent winner.
  function automatic logic exp_ready(input int n);
    exp_ready = !rst && !m_pend && rq_valid[n] && (!rq_valid[1-n] || m_last != n);
  endfunction

  function automatic logic exp_rsp(input int n);
    exp_rsp = m_pend && (m_age >= 1) && (m_owner == n);
  endfunction

  task automatic model_step();
    m_acc = -1;
    if (rst) return;
    if (!m_pend) begin
      for (int n = 0; n < 2; n++) begin
        if (exp_ready(n) && m_acc < 0) begin
          m_pend = 1'b1; m_age = 0; m_owner = n; m_last = n; m_acc = n;
          m_a1 = rq_rd1[n]; m_a2 = rq_rd2[n]; m_pc = rq_pc[n]; m_imm = rq_imm[n];
          m_as = rq_asel[n]; m_bs = rq_bsel[n]; m_op = rq_op[n];
          m_res = ref_alu(m_as ? m_pc : m_a1, m_bs ? m_imm : m_a2, m_op);
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rs_ready[m_owner]) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic compare();
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("ready%0d", n), 32'(dut_rdy[n]), 32'(exp_ready(n)));
      chk($sformatf("rsp%0d_valid", n), 32'(dut_rsp_v[n]), 32'(exp_rsp(n)));
      if (exp_rsp(n)) chk($sformatf("rsp%0d_result", n), dut_res[n], m_res);
      if (rst) chk($sformatf("rsp%0d_result_rst", n), dut_res[n], 32'd0);
    end
    chk("alu_rdata1", alu_rdata1, m_a1);
    chk("alu_rdata2", alu_rdata2, m_a2);
    chk("alu_pc", alu_pc, m_pc);
    chk("alu_imm", alu_imm, m_imm);
    chk("alu_asel", 32'(alu_asel), 32'(m_as));
    chk("alu_bsel", 32'(alu_bsel), 32'(m_bs));
    chk("alu_operation", 32'(alu_operation), 32'(m_op));
  endtask

  // Inputs are set just after a falling edge; check, then advance one clock.
  task automatic cycle();
    #1;
    compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic as, input logic bs, input logic [3:0] op);
    rq_rd1[n] = a; rq_rd2[n] = b; rq_pc[n] = pc; rq_imm[n] = imm;
    rq_asel[n] = as; rq_bsel[n] = bs; rq_op[n] = op;
    rq_valid[n] = 1'b1;
  endtask

  task automatic wait_accept(input int n);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_acc >= 0) break;
    end
    chk($sformatf("accept_req%0d", n), 32'(m_acc), 32'(n));
  endtask

  task automatic wait_rsp(input int n, input logic [31:0] lit, input string name);
    for (int i = 0; i < 20; i++) begin
      if (dut_rsp_v[n]) break;
      cycle();
    end
    chk({name, "_valid"}, 32'(dut_rsp_v[n]), 32'd1);
    chk(name, dut_res[n], lit);
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    rq_valid = '0; rq_rd1 = '0; rq_rd2 = '0; rq_pc = '0; rq_imm = '0;
    rq_asel = '0; rq_bsel = '0; rq_op = '0; rs_ready = 2'b11;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rq_valid = 2'b11;
    cycle(); cycle();
    chk("rst_alu_op", 32'(alu_operation), 32'd0);
    rq_valid = 2'b00;
    rst = 1'b0;

    // Single add with fixed latency
    set_req(0, 32'd12345, 32'd123, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    wait_accept(0);
    rq_valid[0] = 1'b0;
    chk("lat_exec_rsp0", 32'(dut_rsp_v[0]), 32'd0);
    cycle();
    chk("lat_rsp0_valid", 32'(dut_rsp_v[0]), 32'd1);
    chk("add_result", dut_res[0], 32'd12468);
    chk("add_rsp1_quiet", 32'(dut_rsp_v[1]), 32'd0);
    cycle();
    chk("lat_idle_rsp0", 32'(dut_rsp_v[0]), 32'd0);

    // Contention straight after reset: req0 then req1, then req0 again
    rst = 1'b1; model_reset(); cycle(); rst = 1'b0;
    set_req(0, 32'd12345, 32'd123, 32'd0, 32'd0, 1'b0, 1'b0, 4'd1);
    set_req(1, 32'hffffffff, 32'h0fffffff, 32'd0, 32'd0, 1'b0, 1'b0, 4'd7);
    wait_accept(0);
    rq_valid[0] = 1'b0;
    wait_rsp(0, 32'd12222, "sub_result");
    wait_accept(1);
    rq_valid[1] = 1'b0;
    wait_rsp(1, 32'd0, "sltu_result");
    rq_valid = 2'b11;
    wait_accept(0);
    rq_valid[0] = 1'b0;
    wait_rsp(0, 32'd12222, "sub_again");
    wait_accept(1);
    rq_valid[1] = 1'b0;
    wait_rsp(1, 32'd0, "sltu_again");

    // PC + immediate path
    set_req(1, 32'd7, 32'd9, 32'd100, 32'd4, 1'b1, 1'b1, 4'd0);
    wait_accept(1);
    rq_valid[1] = 1'b0;
    wait_rsp(1, 32'd104, "pc_imm_result");

    // Response backpressure with the other requester waiting
    rs_ready[0] = 1'b0;
    set_req(0, 32'h0fffffff, 32'hffffffff, 32'd0, 32'd0, 1'b0, 1'b0, 4'd8);
    wait_accept(0);
    rq_valid[0] = 1'b0;
    set_req(1, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp0_valid", 32'(dut_rsp_v[0]), 32'd1);
      chk("bp_slt_result", dut_res[0], 32'd0);
      chk("bp_ready1", 32'(dut_rdy[1]), 32'd0);
      cycle();
    end
    rs_ready[0] = 1'b1;
    cycle();
    chk("bp_grant1", 32'(dut_rdy[1]), 32'd1);
    wait_accept(1);
    rq_valid[1] = 1'b0;
    wait_rsp(1, 32'd3, "bp_add_result");

    // Reset while req0 is in EXEC
    set_req(0, 32'hf0000000, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 4'd6);
    wait_accept(0);
    rq_valid[0] = 1'b0;
    rst = 1'b1;
    model_reset();
    set_req(1, 32'd50, 32'd8, 32'd0, 32'd0, 1'b0, 1'b0, 4'd1);
    cycle(); cycle();
    chk("rst_alu_rdata1", alu_rdata1, 32'd0);
    chk("rst_ready1", 32'(dut_rdy[1]), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready1", 32'(dut_rdy[1]), 32'd1);
    wait_accept(1);
    rq_valid[1] = 1'b0;
    wait_rsp(1, 32'd42, "post_rst_result");

    // Idle: registered operands must hold
    for (int i = 0; i < 10; i++) cycle();
    chk("idle_alu_op", 32'(alu_operation), 32'd1);
    chk("idle_alu_rdata1", alu_rdata1, 32'd50);
    chk("idle_alu_rdata2", alu_rdata2, 32'd8);
    chk("idle_rsp1_valid", 32'(dut_rsp_v[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
